// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S serial transmitter for the WM8731 DAC data pin (AUD_DACDAT).
// The codec is bus master, so bclk and lrck are asynchronous inputs. They are
// synchronised into clk and edge-detected there. 16-bit mono samples arrive on a
// valid/ready stream and wait in a small FIFO. Each sample is sent on both channels.
//
// Ports:
//   clk          system clock, the only clock domain
//   reset        asynchronous, active-low reset
//   sample_data  signed PCM sample (W bits)
//   sample_valid sample_data is valid
//   sample_ready FIFO can accept a sample (not full)
//   bclk         codec bit clock (async)
//   lrck         codec DAC LR clock (async), low = left channel
//   dacdat       serial data to the codec
//   underrun     1-cycle pulse when a left-channel load finds the FIFO empty
//
// Optional build macro I2S_TX_STATUS_EN adds two status outputs:
//   underrun_cnt  saturating count of underrun pulses
//   fifo_level    current FIFO occupancy
//
// W must be at least 2.
module i2s_dac_tx #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           sample_data,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   bclk,
  input  logic                   lrck,
  output logic                   dacdat,
  output logic                   underrun
`ifdef I2S_TX_STATUS_EN
  ,
  output logic [15:0]            underrun_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CntLast = CW'(W);

  typedef enum logic [1:0] {StSync, StDelay, StShift, StPad} state_e;

  // Bit 0 is the first synchroniser stage and bit 1 is the second.
  logic [1:0]    bclk_sync_q, lrck_sync_q;
  logic          bclk_hist_q;
  logic          lr_prev_q, lr_prev_d;
  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dacdat_q, dacdat_d;
  logic          underrun_q, underrun_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;

  logic fall, lrck_s, lr_chg, empty, full, push, pop;

  assign fall         = bclk_hist_q & ~bclk_sync_q[1];
  assign lrck_s       = lrck_sync_q[1];
  assign lr_chg       = lrck_s != lr_prev_q;
  assign empty        = wr_ptr_q == rd_ptr_q;
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign sample_ready = ~full;
  assign push         = sample_valid & ~full;
  assign dacdat       = dacdat_q;
  assign underrun     = underrun_q;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;
    lr_prev_d  = lr_prev_q;
    pop        = 1'b0;
    if (fall) begin
      lr_prev_d = lrck_s;
      // In SYNC only a left start may begin output. After that, every lrck edge reloads.
      if (lr_chg && (state_q != StSync || !lrck_s)) begin
        dacdat_d = 1'b0;  // I2S one-bit delay slot
        state_d  = StDelay;
        cnt_d    = '0;
        if (!lrck_s) begin
          // The empty flag is taken before any push in this cycle, so there is no bypass.
          if (empty) begin
            sh_d       = '0;
            hold_d     = '0;
            underrun_d = 1'b1;
          end else begin
            sh_d   = mem_q[rd_ptr_q[AW-1:0]];
            hold_d = mem_q[rd_ptr_q[AW-1:0]];
            pop    = 1'b1;
          end
        end else begin
          sh_d = hold_q;
        end
      end else begin
        case (state_q)
          StDelay, StShift: begin
            dacdat_d = sh_q[W-1];
            sh_d     = {sh_q[W-2:0], 1'b0};
            cnt_d    = cnt_q + CW'(1);
            state_d  = (cnt_q + CW'(1) == CntLast) ? StPad : StShift;
          end
          StSync, StPad: dacdat_d = 1'b0;
          default:       state_d  = StSync;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_hist_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      state_q     <= StSync;
      sh_q        <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], bclk};
      lrck_sync_q <= {lrck_sync_q[0], lrck};
      bclk_hist_q <= bclk_sync_q[1];
      lr_prev_q   <= lr_prev_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
      wr_ptr_q    <= wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_q    <= rd_ptr_q + {{AW{1'b0}}, pop};
    end
  end

  // FIFO storage needs no reset. The pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sample_data;
  end

`ifdef I2S_TX_STATUS_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_cnt_q <= '0;
    end else if (underrun_d && underrun_cnt_q != 16'hFFFF) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Testbench for i2s_dac_tx. It keeps a behavioural model of each slot: the bit at
// position p after an lrck edge, plus a sample queue. It compares dacdat, underrun
// and sample_ready with the model on every clock.
module tb_i2s_dac_tx;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk = 1'b1;
  logic        lrck = 1'b0;
  logic        dacdat;
  logic        underrun;

  i2s_dac_tx #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .dacdat       (dacdat),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ur_seen = 0;

  // Model state
  logic [15:0] mq[$];
  logic [15:0] tx_q[$];
  logic [15:0] hold = '0, word = '0;
  logic synced = 1'b0, prev_lr = 1'b0, pend_lr = 1'b0;
  logic exp_dacdat = 1'b0, exp_underrun = 1'b0, accepted = 1'b0, rdy;
  int pending = 0;
  int pos = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // One bclk fall as the DUT acts on it: a slot position counter and a bit lookup.
  task automatic process_fall(input logic lr);
    logic chg;
    chg = lr != prev_lr;
    prev_lr = lr;
    if (chg && (synced || !lr)) begin
      if (!lr) begin
        synced = 1'b1;
        if (mq.size() > 0) hold = mq.pop_front();
        else begin
          hold = '0;
          exp_underrun = 1'b1;
        end
      end
      word = hold;
      pos = 0;
      exp_dacdat = 1'b0;
    end else if (synced) begin
      if (pos <= W) pos++;
      exp_dacdat = (pos >= 1 && pos <= W) ? word[W-pos] : 1'b0;
    end else begin
      exp_dacdat = 1'b0;
    end
  endtask

  // Model update, clocked like the DUT: a fall acts 3 clocks after the pin edge.
  // The pop decision comes before the push.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        mq.delete();
        hold = '0; word = '0; synced = 1'b0; prev_lr = 1'b0;
        pending = 0; pos = 0; exp_dacdat = 1'b0; exp_underrun = 1'b0; accepted = 1'b0;
      end else begin
        rdy = mq.size() < DEPTH;
        exp_underrun = 1'b0;
        if (pending > 0) begin
          pending--;
          if (pending == 0) process_fall(pend_lr);
        end
        if (sample_valid && rdy) begin
          mq.push_back(sample_data);
          accepted = 1'b1;
        end
      end
    end
  end

  // Stream driver: present the head of tx_q and hold it until accepted.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (accepted && tx_q.size() > 0) tx_q.delete(0);
      accepted = 1'b0;
      if (tx_q.size() > 0) begin
        sample_valid = 1'b1;
        sample_data  = tx_q[0];
      end else begin
        sample_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_dacdat", {31'b0, dacdat}, 32'd0);
        chk("rst_underrun", {31'b0, underrun}, 32'd0);
        chk("rst_ready", {31'b0, sample_ready}, 32'd1);
      end else begin
        chk("dacdat", {31'b0, dacdat}, {31'b0, exp_dacdat});
        chk("underrun", {31'b0, underrun}, {31'b0, exp_underrun});
        chk("ready", {31'b0, sample_ready}, {31'b0, mq.size() < DEPTH});
      end
      if (underrun === 1'b1) ur_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tx_q.delete();
    sample_valid = 1'b0;
    bclk = 1'b1;
    lrck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // m bclk periods with lrck at lr. Each phase lasts ph clocks.
  // cap collects dacdat as sampled at each rise.
  task automatic half(input logic lr, input int m, input int ph, input logic inj_en,
                      input logic [15:0] inj, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < m; i++) begin
      @(posedge clk);
      #1;
      bclk = 1'b0;
      if (i == 0) lrck = lr;
      pend_lr = lrck;
      pending = 3;
      for (int k = 0; k < ph; k++) begin
        @(posedge clk);
        #1;
        // Lands the push on the same clock as the load that this fall causes.
        if (inj_en && i == 0 && k == 1) tx_q.push_back(inj);
      end
      cap = {cap[30:0], dacdat};
      bclk = 1'b1;
      repeat (ph - 1) @(posedge clk);
    end
  endtask

  logic [31:0] c;
  int ur0;

  initial begin
    do_reset();

    // Single sample, 64 bclk per frame, sent on both channels
    tx_q.push_back(16'hA5C3);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);
    half(1'b0, 32, 4, 1'b0, 16'h0, c);
    chk("t2_left_slot", c, 32'h52E1_8000);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);
    chk("t2_right_slot", c, 32'h52E1_8000);

    // Three frames with no data
    ur0 = ur_seen;
    for (int f = 0; f < 3; f++) begin
      half(1'b0, 32, 4, 1'b0, 16'h0, c);
      chk("t3_left_zero", c, 32'd0);
      half(1'b1, 32, 4, 1'b0, 16'h0, c);
      chk("t3_right_zero", c, 32'd0);
    end
    repeat (4) @(posedge clk);
    chk("t3_underrun_pulses", 32'(ur_seen - ur0), 32'd3);

    // Push arrives on the same clock as a left load from an empty FIFO
    ur0 = ur_seen;
    half(1'b0, 32, 4, 1'b1, 16'h3C5A, c);
    chk("t6_left_zero", c, 32'd0);
    chk("t6_underrun", 32'(ur_seen - ur0), 32'd1);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);
    chk("t6_right_zero", c, 32'd0);
    half(1'b0, 32, 4, 1'b0, 16'h0, c);
    chk("t6_next_left", c, 32'h1E2D_0000);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);

    // FIFO fill with no bclk
    do_reset();
    tx_q.push_back(16'h1111); tx_q.push_back(16'h2222); tx_q.push_back(16'h3333);
    tx_q.push_back(16'h4444); tx_q.push_back(16'h5555);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t4_ready_full", {31'b0, sample_ready}, 32'd0);
    chk("t4_fifth_stalled", 32'(tx_q.size()), 32'd1);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);
    chk("t4_right_no_pop", 32'(tx_q.size()), 32'd1);
    half(1'b0, 32, 4, 1'b0, 16'h0, c);
    chk("t4_left_slot", c, 32'h0888_8000);
    chk("t4_fifth_taken", 32'(tx_q.size()), 32'd0);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);

    // Reset in the middle of a word
    half(1'b0, 10, 4, 1'b0, 16'h0, c);
    do_reset();
    @(negedge clk);
    chk("t1_dacdat", {31'b0, dacdat}, 32'd0);
    chk("t1_ready", {31'b0, sample_ready}, 32'd1);
    chk("t1_underrun", {31'b0, underrun}, 32'd0);
    tx_q.push_back(16'h0F0F);
    half(1'b0, 32, 4, 1'b0, 16'h0, c);
    chk("t1_no_partial", c, 32'd0);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);
    chk("t1_right_ignored", c, 32'd0);
    half(1'b0, 32, 4, 1'b0, 16'h0, c);
    chk("t1_resume_left", c, 32'h0787_8000);
    half(1'b1, 32, 4, 1'b0, 16'h0, c);

    // 32 bclk per frame, then a truncated left slot
    tx_q.push_back(16'hA5C3);
    half(1'b0, 16, 4, 1'b0, 16'h0, c);
    chk("t5_left16", c, 32'h0000_52E1);
    half(1'b1, 16, 4, 1'b0, 16'h0, c);
    chk("t5_right16", c, 32'h0000_52E1);
    tx_q.push_back(16'h1234);
    half(1'b0, 8, 4, 1'b0, 16'h0, c);
    chk("t5_trunc_left", c, 32'h0000_0009);
    half(1'b1, 16, 4, 1'b0, 16'h0, c);
    chk("t5_right_after_trunc", c, 32'h0000_091A);

    // Randomised frames, checked by the per-cycle model
    for (int f = 0; f < 24; f++) begin
      int n, ph, k, m;
      logic inj_en;
      n  = 12 + 4 * $urandom_range(0, 5);
      ph = $urandom_range(2, 5);
      k  = $urandom_range(0, 2);
      for (int j = 0; j < k; j++)
        if (tx_q.size() < 6) tx_q.push_back(16'($urandom));
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(3, n) : n;
      inj_en = ($urandom_range(0, 4) == 0);
      half(1'b0, m, ph, inj_en, 16'($urandom), c);
      half(1'b1, n, ph, 1'b0, 16'h0, c);
    end

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
